alu_pipe_unit: RTL and testbench
================================

ALU_PIPE_UNIT -- requirements
Module: alu_pipe_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width W; legal 32 or 64.
REQ-002 Parameter FIFO_DEPTH, default 4: result buffer entries; power of two, 2..16.
REQ-003 Parameter ID_WIDTH, default 3: width of instruction tag carried with each result.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  request present this cycle.
REQ-007 issue_ready  output  1  unit can accept a request this cycle.
REQ-008 in1, in2  input  W+1  operands; bit W is sign-pad (1 = signed extension for SLT/SRA).
REQ-009 subtract  input  1  add/SLT path computes in1-in2.
REQ-010 arith  input  1  right shift fills with in1[W].
REQ-011 lshift  input  1  shift/rotate direction left.
REQ-012 logic_op  input  2  00 add, 01 xor, 10 or, 11 and.
REQ-013 op  input  2  00 add/logic, 01 slt, 10 shift, 11 rotate.
REQ-014 id  input  ID_WIDTH  tag returned with result.
REQ-015 flush  input  1  discard all buffered results.
REQ-016 wb_valid  output  1  result at buffer head.
REQ-017 wb_rd  output  W  head result.
REQ-018 wb_id  output  ID_WIDTH  head tag.
REQ-019 wb_accepted  input  1  consumer takes head this cycle; ignored when wb_valid low.

Function
REQ-020 Request accepted when issue_valid & issue_ready & ~flush; result computed combinationally and written to buffer on that edge.
REQ-021 issue_ready SHALL equal (count != FIFO_DEPTH); no same-cycle pop credit.
REQ-022 Latency: request accepted at edge N with empty buffer -> wb_valid high after edge N, i.e. during cycle N+1.
REQ-023 Add: in1[W-1:0] +/- in2[W-1:0] modulo 2^W; logic ops ignore subtract.
REQ-024 SLT: (W+1)-bit in1 - in2 regardless of subtract; result = zero-extended bit W of difference.
REQ-025 Shift amount = in2[log2(W)-1:0]; left shift zero-fills; right shift fills with (arith & in1[W]).
REQ-026 Rotate: circular by same amount, direction by lshift; arith ignored.
REQ-027 Buffer strictly FIFO; wb_rd/wb_id stable while wb_valid & ~wb_accepted.
REQ-028 Simultaneous push and pop when 0 < count < FIFO_DEPTH: count unchanged, order preserved.
REQ-029 Push into empty with no pop: count 0->1; pop from count 1 with no push: wb_valid low next cycle.
REQ-030 Pointers wrap modulo FIFO_DEPTH with no bubble.
REQ-031 flush: count, pointers cleared on that edge; same-cycle issue and wb_accepted ignored; wb_valid low next cycle.

Reset
REQ-032 On rst low, immediately: count=0, pointers=0, wb_valid=0, issue_ready=1; wb_rd, wb_id = 0.
REQ-033 Reset mid-operation discards all buffered results; no result reappears after release.
REQ-034 First request accepted on first rising edge after rst deasserted.

Structure
REQ-035 op and logic_op encodings SHALL be enum typedefs (alu_op_t, alu_logic_op_t) in cva5_types; alu_pipe_inputs_t struct bundles in1..id.
REQ-036 Buffer SHALL be sub-module alu_result_fifo (parametrised width, depth; push, pop, flush, full, valid).
REQ-037 Compute datapath is single combinational stage inside alu_pipe_unit.

Verification
REQ-038 W=32: add 3+7 -> 0x0000000a; sub 3-7 -> 0xfffffffc; xor 0xff00ff00^0x0f0f0f0f -> 0xf00ff00f.
REQ-039 SLT signed in1=0x1_ffffffff (-1), in2=0x0_00000001 -> 1; unsigned pads 0 same values -> 0.
REQ-040 SRA 0x80000000 by 7 arith=1 -> 0xff000000; rotate left 0x80000001 by 1 -> 0x00000003; W=64 SLL 1 by 63 -> 0x8000000000000000.
REQ-041 Backpressure: wb_accepted held low, issue 5 requests at DEPTH 4 -> issue_ready low after 4th; release -> ids emerge 0,1,2,3 then 4.
REQ-042 Flush with 3 buffered while issue_valid high -> wb_valid low next cycle, nothing from that cycle buffered.
REQ-043 Random 1000 ops, random accept latency 0..15, randomized async reset mid-stream -> all results match model, in order.

Source files
------------

// File: rtl/alu_pipe_unit_pkg.sv
// Shared types for the ALU pipe unit.
//   alu_op_t          : top-level operation select (add/logic, slt, shift, rotate)
//   alu_logic_op_t    : sub-select for the add/logic path
//   alu_pipe_inputs_t : one issued request (operands, controls, tag), sized for
//                       the widest legal configuration; narrower units zero-pad.
package cva5_types;

    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_ID_WIDTH   = 16;

    typedef enum logic [1:0] {
        ALU_OP_ADD_LOGIC = 2'b00,
        ALU_OP_SLT       = 2'b01,
        ALU_OP_SHIFT     = 2'b10,
        ALU_OP_ROTATE    = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_LOGIC_ADD = 2'b00,
        ALU_LOGIC_XOR = 2'b01,
        ALU_LOGIC_OR  = 2'b10,
        ALU_LOGIC_AND = 2'b11
    } alu_logic_op_t;

    typedef struct packed {
        logic [MAX_DATA_WIDTH:0]   in1;
        logic [MAX_DATA_WIDTH:0]   in2;
        logic                      subtract;
        logic                      arith;
        logic                      lshift;
        alu_logic_op_t             logic_op;
        alu_op_t                   op;
        logic [MAX_ID_WIDTH-1:0]   id;
    } alu_pipe_inputs_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result buffer for the ALU pipe unit: a circular FIFO.
//   clk, rst (async, active-low)
//   push/data_in : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : synchronously empty the buffer; same-cycle push/pop ignored
//   data_out     : head entry, stable until popped
//   full, valid  : count == DEPTH, count != 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_result_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             valid
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic                 push_s;
    logic                 pop_s;

    assign full     = (count_r == CNT_WIDTH'(DEPTH));
    assign valid    = (count_r != '0);
    assign push_s   = push & ~full & ~flush;
    assign pop_s    = pop & valid & ~flush;
    assign data_out = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush returns everything to the empty state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/alu_pipe_unit.sv
// Single-stage ALU with a buffered, in-order writeback.
//   clk, rst (async, active-low)
//   issue_valid/issue_ready : request handshake; ready = buffer not full
//   in1, in2 (W+1 bits)     : operands, bit W is the sign pad used by SLT/SRA
//   subtract, arith, lshift, logic_op, op, id : operation controls and tag
//   flush                   : drop all buffered results, ignore same-cycle issue
//   wb_valid, wb_rd, wb_id  : head of the result buffer
//   wb_accepted             : consumer pops the head this cycle
module alu_pipe_unit
    import cva5_types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH:0]   in1,
    input  logic [DATA_WIDTH:0]   in2,
    input  logic                  subtract,
    input  logic                  arith,
    input  logic                  lshift,
    input  logic [1:0]            logic_op,
    input  logic [1:0]            op,
    input  logic [ID_WIDTH-1:0]   id,
    input  logic                  flush,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_rd,
    output logic [ID_WIDTH-1:0]   wb_id,
    input  logic                  wb_accepted
);
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int ENTRY_WIDTH = DATA_WIDTH + ID_WIDTH;

    alu_pipe_inputs_t          req_s;
    logic [DATA_WIDTH:0]       a_s;
    logic [DATA_WIDTH:0]       b_s;
    logic [SHAMT_WIDTH-1:0]    shamt_s;
    logic [DATA_WIDTH-1:0]     addsub_s;
    logic [DATA_WIDTH:0]       slt_diff_s;
    logic                      shift_fill_s;
    logic [DATA_WIDTH:0]       shr_s;
    logic [2*DATA_WIDTH-1:0]   rot_l_s;
    logic [2*DATA_WIDTH-1:0]   rot_r_s;
    logic [DATA_WIDTH-1:0]     result_s;
    logic                      full_s;
    logic                      push_s;
    logic                      pop_s;
    logic [ENTRY_WIDTH-1:0]    head_s;
    logic                      unused_s;

    // Bundle the request into the shared struct; unused high bits stay zero.
    always_comb begin
        req_s                     = '0;
        req_s.in1[DATA_WIDTH:0]   = in1;
        req_s.in2[DATA_WIDTH:0]   = in2;
        req_s.subtract            = subtract;
        req_s.arith               = arith;
        req_s.lshift              = lshift;
        req_s.logic_op            = alu_logic_op_t'(logic_op);
        req_s.op                  = alu_op_t'(op);
        req_s.id[ID_WIDTH-1:0]    = id;
    end

    assign a_s     = req_s.in1[DATA_WIDTH:0];
    assign b_s     = req_s.in2[DATA_WIDTH:0];
    assign shamt_s = b_s[SHAMT_WIDTH-1:0];

    assign addsub_s = req_s.subtract ? (a_s[DATA_WIDTH-1:0] - b_s[DATA_WIDTH-1:0])
                                     : (a_s[DATA_WIDTH-1:0] + b_s[DATA_WIDTH-1:0]);

    // SLT always subtracts across the sign pad; the pad bit of the difference is the answer.
    assign slt_diff_s = a_s - b_s;

    // Right shift: put the fill bit on top and shift arithmetically so it replicates.
    assign shift_fill_s = req_s.arith & a_s[DATA_WIDTH];
    assign shr_s        = $signed({shift_fill_s, a_s[DATA_WIDTH-1:0]}) >>> shamt_s;

    // Rotates via a doubled word: left takes the upper half, right the lower half.
    assign rot_l_s = {a_s[DATA_WIDTH-1:0], a_s[DATA_WIDTH-1:0]} << shamt_s;
    assign rot_r_s = {a_s[DATA_WIDTH-1:0], a_s[DATA_WIDTH-1:0]} >> shamt_s;

    // Result select.
    always_comb begin
        result_s = '0;
        case (req_s.op)
            ALU_OP_ADD_LOGIC: begin
                case (req_s.logic_op)
                    ALU_LOGIC_ADD: result_s = addsub_s;
                    ALU_LOGIC_XOR: result_s = a_s[DATA_WIDTH-1:0] ^ b_s[DATA_WIDTH-1:0];
                    ALU_LOGIC_OR:  result_s = a_s[DATA_WIDTH-1:0] | b_s[DATA_WIDTH-1:0];
                    ALU_LOGIC_AND: result_s = a_s[DATA_WIDTH-1:0] & b_s[DATA_WIDTH-1:0];
                    default:       result_s = addsub_s;
                endcase
            end
            ALU_OP_SLT: begin
                result_s = {{(DATA_WIDTH-1){1'b0}}, slt_diff_s[DATA_WIDTH]};
            end
            ALU_OP_SHIFT: begin
                if (req_s.lshift) begin
                    result_s = a_s[DATA_WIDTH-1:0] << shamt_s;
                end else begin
                    result_s = shr_s[DATA_WIDTH-1:0];
                end
            end
            ALU_OP_ROTATE: begin
                if (req_s.lshift) begin
                    result_s = rot_l_s[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    result_s = rot_r_s[DATA_WIDTH-1:0];
                end
            end
            default: result_s = addsub_s;
        endcase
    end

    // Bits that are produced as a by-product of the datapath but never selected.
    assign unused_s = ^{req_s, shr_s[DATA_WIDTH], rot_l_s[DATA_WIDTH-1:0],
                        rot_r_s[2*DATA_WIDTH-1:DATA_WIDTH], slt_diff_s[DATA_WIDTH-1:0]};

    assign issue_ready = ~full_s;
    assign push_s      = issue_valid & issue_ready & ~flush;
    assign pop_s       = wb_accepted & wb_valid & ~flush;

    alu_result_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (flush),
        .data_in  ({id, result_s}),
        .data_out (head_s),
        .full     (full_s),
        .valid    (wb_valid)
    );

    assign {wb_id, wb_rd} = head_s;

endmodule

// File: tb/tb_alu_pipe_unit.sv
module tb_alu_pipe_unit;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid, issue_ready;
    logic [W:0]    in1, in2;
    logic          subtract, arith, lshift, flush, wb_valid, wb_accepted;
    logic [1:0]    logic_op, op;
    logic [IW-1:0] id, wb_id;
    logic [W-1:0]  wb_rd;

    logic          issue_valid64, issue_ready64, wb_valid64;
    logic [64:0]   in1_64, in2_64;
    logic [63:0]   wb_rd64;
    logic [IW-1:0] wb_id64;

    always #5 clk = ~clk;

    alu_pipe_unit #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in1(in1), .in2(in2), .subtract(subtract), .arith(arith), .lshift(lshift),
        .logic_op(logic_op), .op(op), .id(id), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_id(wb_id), .wb_accepted(wb_accepted));

    alu_pipe_unit #(.DATA_WIDTH(64), .FIFO_DEPTH(D), .ID_WIDTH(IW)) dut64 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid64), .issue_ready(issue_ready64),
        .in1(in1_64), .in2(in2_64), .subtract(1'b0), .arith(1'b0), .lshift(1'b1),
        .logic_op(2'b00), .op(2'b10), .id(3'd5), .flush(1'b0),
        .wb_valid(wb_valid64), .wb_rd(wb_rd64), .wb_id(wb_id64), .wb_accepted(1'b0));

    typedef struct {
        logic [W-1:0]  rd;
        logic [IW-1:0] id;
    } entry_t;

    entry_t        model_q[$];
    logic [IW-1:0] popped[$];
    int            checks = 0;
    int            errors = 0;
    int            accepted_ops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: operation semantics computed bit by bit / with wide arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [W:0] a, input logic [W:0] b,
                                             input logic sub, input logic ar, input logic ls,
                                             input logic [1:0] lop, input logic [1:0] o);
        logic [W-1:0] x, y, r;
        logic [63:0]  wide;
        int           amt;
        x    = a[W-1:0];
        y    = b[W-1:0];
        amt  = int'(b[$clog2(W)-1:0]);
        r    = '0;
        case (o)
            2'd0: begin
                case (lop)
                    2'd0:    r = sub ? x - y : x + y;
                    2'd1:    r = x ^ y;
                    2'd2:    r = x | y;
                    default: r = x & y;
                endcase
            end
            2'd1: begin
                wide = {31'd0, a} - {31'd0, b};
                r    = W'(wide[W]);
            end
            2'd2: begin
                for (int i = 0; i < W; i++) begin
                    if (ls) r[i] = (i >= amt) ? x[i-amt] : 1'b0;
                    else    r[i] = (i + amt < W) ? x[i+amt] : (ar & a[W]);
                end
            end
            default: begin
                for (int i = 0; i < W; i++) begin
                    if (ls) r[i] = x[(i - amt + W) % W];
                    else    r[i] = x[(i + amt) % W];
                end
            end
        endcase
        return r;
    endfunction

    // One clock: compare outputs with the model, then advance both across the edge.
    task automatic step();
        bit     acc, pop;
        entry_t e;
        check("issue_ready", issue_ready, 64'(model_q.size() != D));
        check("wb_valid", wb_valid, 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("wb_rd", wb_rd, model_q[0].rd);
            check("wb_id", wb_id, model_q[0].id);
        end
        acc  = issue_valid && (model_q.size() != D) && !flush;
        pop  = wb_accepted && (model_q.size() != 0) && !flush;
        if (wb_valid && wb_accepted && !flush) popped.push_back(wb_id);
        e.rd = ref_alu(in1, in2, subtract, arith, lshift, logic_op, op);
        e.id = id;
        @(posedge clk);
        #1;
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(e);
                accepted_ops++;
            end
        end
    endtask

    task automatic set_req(input logic [W:0] a, input logic [W:0] b, input logic sub,
                           input logic ar, input logic ls, input logic [1:0] lop,
                           input logic [1:0] o, input logic [IW-1:0] t);
        issue_valid = 1'b1; in1 = a; in2 = b; subtract = sub; arith = ar;
        lshift = ls; logic_op = lop; op = o; id = t;
    endtask

    task automatic directed(input string tag, input logic [W:0] a, input logic [W:0] b,
                            input logic sub, input logic ar, input logic ls,
                            input logic [1:0] lop, input logic [1:0] o, input logic [W-1:0] exp);
        wb_accepted = 1'b0;
        set_req(a, b, sub, ar, ls, lop, o, 3'd1);
        step();
        issue_valid = 1'b0;
        check({tag, "_lat"}, wb_valid, 64'd1);
        check(tag, wb_rd, exp);
        wb_accepted = 1'b1;
        step();
        wb_accepted = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt, reset_at, budget;
        bit reset_done, pop_exp;
        issue_valid = 1'b0; in1 = '0; in2 = '0; subtract = 1'b0; arith = 1'b0;
        lshift = 1'b0; logic_op = 2'd0; op = 2'd0; id = '0; flush = 1'b0;
        wb_accepted = 1'b0; issue_valid64 = 1'b0; in1_64 = '0; in2_64 = '0;

        #12;
        check("rst_ready", issue_ready, 64'd1);
        check("rst_valid", wb_valid, 64'd0);
        check("rst_rd", wb_rd, 64'd0);
        check("rst_id", wb_id, 64'd0);
        rst = 1'b1;

        // First request lands on the first edge after release.
        directed("add", 33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0000000a);
        directed("sub", 33'd3, 33'd7, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'hfffffffc);
        directed("xor", 33'h0_ff00ff00, 33'h0_0f0f0f0f, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 32'hf00ff00f);
        directed("and_sub_ign", 33'h0_0000f0f0, 33'h0_0000ff00, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 32'h0000f000);
        directed("slt_s", 33'h1_ffffffff, 33'h0_00000001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd1);
        directed("slt_u", 33'h0_ffffffff, 33'h0_00000001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0);
        directed("sra", 33'h1_80000000, 33'd7, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 32'hff000000);
        directed("srl", 33'h1_80000000, 33'd7, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 32'h01000000);
        directed("rol", 33'h0_80000001, 33'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 32'h00000003);
        directed("ror", 33'h0_80000001, 33'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 32'hc0000000);

        issue_valid64 = 1'b1; in1_64 = 65'd1; in2_64 = 65'd63;
        step();
        issue_valid64 = 1'b0;
        check("sll64_valid", wb_valid64, 64'd1);
        check("sll64", wb_rd64, 64'h8000000000000000);
        check("sll64_id", wb_id64, 64'd5);

        // Backpressure: four fill the buffer, the fifth waits for a free slot.
        popped.delete();
        wb_accepted = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(33'(k), 33'd100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, IW'(k));
            step();
        end
        check("bp_ready_low", issue_ready, 64'd0);
        set_req(33'd4, 33'd100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd4);
        step();
        check("bp_still_low", issue_ready, 64'd0);
        wb_accepted = 1'b1;
        step();
        step();
        issue_valid = 1'b0;
        for (int k = 0; k < 10 && model_q.size() != 0; k++) step();
        wb_accepted = 1'b0;
        check("bp_count", popped.size(), 64'd5);
        for (int k = 0; k < 5 && k < popped.size(); k++) check("bp_order", popped[k], 64'(k));

        // Flush with three buffered and a same-cycle issue and accept.
        for (int k = 0; k < 3; k++) begin
            set_req(33'(k + 10), 33'd1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, IW'(k));
            step();
        end
        set_req(33'd99, 33'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd7);
        flush = 1'b1;
        wb_accepted = 1'b1;
        step();
        flush = 1'b0; issue_valid = 1'b0; wb_accepted = 1'b0;
        check("flush_valid", wb_valid, 64'd0);
        check("flush_ready", issue_ready, 64'd1);
        step();
        step();

        // Random traffic with random consumer latency and one async reset.
        accepted_ops = 0;
        wait_cnt     = $urandom_range(15, 0);
        reset_at     = $urandom_range(700, 200);
        reset_done   = 1'b0;
        budget       = 0;
        while (accepted_ops < 1000 && budget < 60000) begin
            issue_valid = ($urandom_range(3, 0) != 0);
            in1         = {1'($urandom_range(1, 0)), 32'($urandom())};
            in2         = {1'($urandom_range(1, 0)), 32'($urandom())};
            subtract    = 1'($urandom_range(1, 0));
            arith       = 1'($urandom_range(1, 0));
            lshift      = 1'($urandom_range(1, 0));
            logic_op    = 2'($urandom_range(3, 0));
            op          = 2'($urandom_range(3, 0));
            id          = IW'($urandom_range(7, 0));
            flush       = ($urandom_range(199, 0) == 0);
            if (model_q.size() != 0) begin
                if (wait_cnt == 0) begin
                    wb_accepted = 1'b1;
                end else begin
                    wb_accepted = 1'b0;
                    wait_cnt--;
                end
            end else begin
                wb_accepted = 1'($urandom_range(1, 0));
            end
            pop_exp = wb_accepted && (model_q.size() != 0) && !flush;
            step();
            budget++;
            if (pop_exp) wait_cnt = $urandom_range(15, 0);
            if (!reset_done && accepted_ops >= reset_at) begin
                reset_done = 1'b1;
                #3;
                rst = 1'b0;
                #1;
                check("mid_rst_ready", issue_ready, 64'd1);
                check("mid_rst_valid", wb_valid, 64'd0);
                check("mid_rst_rd", wb_rd, 64'd0);
                check("mid_rst_id", wb_id, 64'd0);
                model_q.delete();
                #2;
                rst = 1'b1;
            end
        end
        flush = 1'b0;
        check("random_done", 64'(accepted_ops >= 1000), 64'd1);
        check("random_reset", 64'(reset_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
